// File: rtl/i2c_master_write_fsm.sv
// I2C master transmitter: START, {addr, W}, two data bytes, STOP, checking the slave ACK after each byte.
// Optional feature macro CLOCK_STRETCH_EN: the divider holds while a released SCL is still seen low.
module i2c_master_write_fsm #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] slave_addr,
    input  logic [7:0] data1,
    input  logic [7:0] data2,
    input  logic       sda_in,
    input  logic       scl_in,
    output logic       sda_oe,
    output logic       scl_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_error
);

    localparam int unsigned DIV_W = 8;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        IDLE,
        START,
        ADDR,
        ACK_A,
        DATA1,
        ACK_1,
        DATA2,
        ACK_2,
        STOP
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] div;
    logic [1:0]       phase;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;
    logic [7:0]       data1_q;
    logic [7:0]       data2_q;
    logic             nack;
    logic             hold_c;
    logic [7:0]       next_byte_c;

`ifdef CLOCK_STRETCH_EN
    // A slave keeping SCL low after we released it freezes the quarter count.
    assign hold_c = !scl_oe && !scl_in;
`else
    logic unused_scl_in;
    assign unused_scl_in = scl_in;
    assign hold_c        = 1'b0;
`endif

    assign next_byte_c = (state == ACK_A) ? data1_q : data2_q;

    // Quarter-stepped transfer sequencer; outputs are set for the quarter being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            div       <= '0;
            phase     <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            data1_q   <= '0;
            data2_q   <= '0;
            nack      <= 1'b0;
            sda_oe    <= 1'b0;
            scl_oe    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ack_error <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                div   <= '0;
                phase <= '0;
                if (start) begin
                    state     <= START;
                    busy      <= 1'b1;
                    ack_error <= 1'b0;
                    nack      <= 1'b0;
                    shreg     <= {slave_addr, 1'b0};
                    data1_q   <= data1;
                    data2_q   <= data2;
                end
            end else if (!hold_c) begin
                if (div != DIV_LAST) begin
                    div <= div + 1'b1;
                end else begin
                    div   <= '0;
                    phase <= phase + 1'b1;
                    case (state)
                        START: begin
                            if (phase == 2'd0) begin
                                sda_oe <= 1'b1;
                            end else begin
                                state   <= ADDR;
                                phase   <= '0;
                                bit_cnt <= 3'd7;
                                scl_oe  <= 1'b1;
                                sda_oe  <= ~shreg[7];
                            end
                        end
                        ADDR, DATA1, DATA2: begin
                            if (phase == 2'd1) begin
                                scl_oe <= 1'b0;
                            end else if (phase == 2'd3) begin
                                scl_oe <= 1'b1;
                                if (bit_cnt != 3'd0) begin
                                    bit_cnt <= bit_cnt - 1'b1;
                                    shreg   <= {shreg[6:0], 1'b0};
                                    sda_oe  <= ~shreg[6];
                                end else begin
                                    sda_oe <= 1'b0;
                                    state  <= (state == ADDR)  ? ACK_A :
                                              (state == DATA1) ? ACK_1 : ACK_2;
                                end
                            end
                        end
                        ACK_A, ACK_1, ACK_2: begin
                            if (phase == 2'd1) begin
                                scl_oe <= 1'b0;
                            end else if (phase == 2'd2) begin
                                nack <= sda_in;
                            end else if (phase == 2'd3) begin
                                scl_oe <= 1'b1;
                                // A NACK skips every remaining byte.
                                if (nack || state == ACK_2) begin
                                    state  <= STOP;
                                    sda_oe <= 1'b1;
                                    if (nack) begin
                                        ack_error <= 1'b1;
                                    end
                                end else begin
                                    state   <= (state == ACK_A) ? DATA1 : DATA2;
                                    shreg   <= next_byte_c;
                                    bit_cnt <= 3'd7;
                                    sda_oe  <= ~next_byte_c[7];
                                end
                            end
                        end
                        STOP: begin
                            if (phase == 2'd0) begin
                                scl_oe <= 1'b0;
                            end else begin
                                state  <= IDLE;
                                sda_oe <= 1'b0;
                                busy   <= 1'b0;
                                done   <= 1'b1;
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule
